// File: rtl/cpu_perf_pkg.sv
// Shared definitions for the pipeline performance monitor: FSM states and
// read-port address map.
package cpu_perf_pkg;

  typedef enum logic [1:0] {
    PERF_IDLE = 2'd0,
    PERF_RUN  = 2'd1,
    PERF_DONE = 2'd2
  } perf_state_e;

  localparam logic [2:0] PERF_ADDR_CYCLE  = 3'd0;
  localparam logic [2:0] PERF_ADDR_STALL  = 3'd1;
  localparam logic [2:0] PERF_ADDR_FLUSH  = 3'd2;
  localparam logic [2:0] PERF_ADDR_RETIRE = 3'd3;
  localparam logic [2:0] PERF_ADDR_TRACE  = 3'd4;

  localparam int PERF_NUM_CNT = 4;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter: clears on clr_i, otherwise counts inc_i while en_i,
// sticking at all-ones. cnt_d_o exposes the value the next edge will load.
module perf_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_d_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: cycle/stall/flush/retire counters with an
// atomic shadow snapshot and a registered read port. Optional flush-PC trace
// ring enabled by PERF_FLUSH_TRACE_EN (TRACE_DEPTH must be a power of 2, >= 2).
module pipe_perf_monitor
  import cpu_perf_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MAX_CYCLES  = 100,
  parameter int TRACE_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic [31:0]      pc_i,
  input  logic             snap_i,
  input  logic             clr_i,
  input  logic             rd_req_i,
  input  logic [2:0]       rd_addr_i,
  output logic             rd_valid_o,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             running_o,
  output logic             done_o
);

  localparam logic [CNT_W:0] MAX_EXT = (CNT_W+1)'(MAX_CYCLES);

  perf_state_e      state_q, state_d;
  logic             run;
  logic             hit;
  logic             done_entry;
  logic [PERF_NUM_CNT-1:0] inc;
  logic [CNT_W-1:0] live_q   [PERF_NUM_CNT];
  logic [CNT_W-1:0] live_d   [PERF_NUM_CNT];
  logic [CNT_W-1:0] shadow_q [PERF_NUM_CNT];
  logic [CNT_W-1:0] shadow_d [PERF_NUM_CNT];
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0] rd_word;
  logic [CNT_W-1:0] trace_word;

  assign run = (state_q == PERF_RUN);

  // Index order matches the read address map; a branch stall counts as a flush only.
  assign inc = {retire_i, flush_i, stall_i & ~flush_i, 1'b1};

  generate
    for (genvar gi = 0; gi < PERF_NUM_CNT; gi++) begin : g_cnt
      perf_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (run),
        .inc_i   (inc[gi]),
        .clr_i   (clr_i),
        .cnt_o   (live_q[gi]),
        .cnt_d_o (live_d[gi])
      );
    end
  endgenerate

  assign hit = (MAX_CYCLES != 0) && run && (live_q[0] != '1) &&
               (({1'b0, live_q[0]} + (CNT_W+1)'(1)) == MAX_EXT);
  assign done_entry = hit && !clr_i;

  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = PERF_IDLE;
    end else begin
      case (state_q)
        PERF_IDLE: if (start_i) state_d = PERF_RUN;
        PERF_RUN: begin
          if (hit)           state_d = PERF_DONE;
          else if (!start_i) state_d = PERF_IDLE;
        end
        PERF_DONE: state_d = PERF_DONE;
        default:   state_d = PERF_IDLE;
      endcase
    end
  end

  // DONE entry captures the post-update totals; a plain snap captures pre-edge values.
  always_comb begin
    for (int i = 0; i < PERF_NUM_CNT; i++) begin
      shadow_d[i] = shadow_q[i];
      if (done_entry) begin
        shadow_d[i] = live_d[i];
      end else if (snap_i) begin
        shadow_d[i] = live_q[i];
      end
    end
  end

  always_comb begin
    case (rd_addr_i)
      PERF_ADDR_CYCLE:  rd_word = shadow_q[0];
      PERF_ADDR_STALL:  rd_word = shadow_q[1];
      PERF_ADDR_FLUSH:  rd_word = shadow_q[2];
      PERF_ADDR_RETIRE: rd_word = shadow_q[3];
      default:          rd_word = trace_word;
    endcase
    rd_valid_d = rd_req_i;
    rd_data_d  = rd_req_i ? rd_word : rd_data_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= PERF_IDLE;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < PERF_NUM_CNT; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      for (int i = 0; i < PERF_NUM_CNT; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

`ifdef PERF_FLUSH_TRACE_EN
  localparam int PTR_W = $clog2(TRACE_DEPTH);

  logic [31:0]      ring_q  [TRACE_DEPTH];
  logic [31:0]      ring_d  [TRACE_DEPTH];
  logic [31:0]      sring_q [TRACE_DEPTH];
  logic [31:0]      sring_d [TRACE_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] sptr_q, sptr_d;
  logic [2:0]       trace_k;
  logic [PTR_W-1:0] rd_idx;

  always_comb begin
    ring_d = ring_q;
    ptr_d  = ptr_q;
    if (clr_i) begin
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        ring_d[i] = '0;
      end
      ptr_d = '0;
    end else if (run && flush_i) begin
      ring_d[ptr_q] = pc_i;
      ptr_d         = ptr_q + PTR_W'(1);
    end
  end

  always_comb begin
    sring_d = sring_q;
    sptr_d  = sptr_q;
    if (done_entry) begin
      sring_d = ring_d;
      sptr_d  = ptr_d;
    end else if (snap_i) begin
      sring_d = ring_q;
      sptr_d  = ptr_q;
    end
  end

  // Entry k back from the newest sits just behind the snapshotted write pointer.
  always_comb begin
    trace_k    = rd_addr_i - PERF_ADDR_TRACE;
    rd_idx     = sptr_q - PTR_W'(1) - PTR_W'(trace_k[1:0]);
    trace_word = '0;
    if (int'(trace_k[1:0]) < TRACE_DEPTH) begin
      trace_word = CNT_W'(sring_q[rd_idx]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q  <= '0;
      sptr_q <= '0;
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        ring_q[i]  <= '0;
        sring_q[i] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      sptr_q  <= sptr_d;
      ring_q  <= ring_d;
      sring_q <= sring_d;
    end
  end
`else
  logic unused_trace;

  assign trace_word   = '0;
  assign unused_trace = ^{pc_i, (TRACE_DEPTH > 0)};
`endif

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign running_o  = (state_q == PERF_RUN);
  assign done_o     = (state_q == PERF_DONE);

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Bench for pipe_perf_monitor: directed steps plus random traffic checked
// against an event-level reference model.
module tb_pipe_perf_monitor;

  localparam int MAX_CYCLES  = 100;
  localparam int TRACE_DEPTH = 4;
  localparam longint unsigned CMAX = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stall, flush, retire, snap, clr, rd_req;
  logic [31:0] pc;
  logic [2:0]  rd_addr;
  logic        rd_valid, running, done;
  logic [31:0] rd_data;

  logic        start2, retire2, snap2, rd_req2;
  logic [2:0]  rd_addr2;
  logic        rd_valid2, running2, done2;
  logic [3:0]  rd_data2;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  pipe_perf_monitor #(.CNT_W(32), .MAX_CYCLES(MAX_CYCLES), .TRACE_DEPTH(TRACE_DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stall_i(stall), .flush_i(flush),
    .retire_i(retire), .pc_i(pc), .snap_i(snap), .clr_i(clr), .rd_req_i(rd_req),
    .rd_addr_i(rd_addr), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .running_o(running), .done_o(done)
  );

  pipe_perf_monitor #(.CNT_W(4), .MAX_CYCLES(0), .TRACE_DEPTH(TRACE_DEPTH)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start2), .stall_i(1'b0), .flush_i(1'b0),
    .retire_i(retire2), .pc_i(32'd0), .snap_i(snap2), .clr_i(1'b0), .rd_req_i(rd_req2),
    .rd_addr_i(rd_addr2), .rd_valid_o(rd_valid2), .rd_data_o(rd_data2),
    .running_o(running2), .done_o(done2)
  );

  // Reference model: counts as plain integers, traces as newest-first queues.
  bit              m_run, m_done;
  longint unsigned m_cnt [4];
  longint unsigned m_sh  [4];
  logic [31:0]     m_tr  [$];
  logic [31:0]     m_str [$];
  logic            m_valid;
  logic [31:0]     m_rd;

  function automatic longint unsigned sat_inc(longint unsigned v);
    return (v == CMAX) ? v : v + 1;
  endfunction

  function automatic logic [31:0] shadow_word(logic [2:0] a);
    int k;
    if (a < 3'd4) return m_sh[a][31:0];
    k = int'(a) - 4;
`ifdef PERF_FLUSH_TRACE_EN
    if (k < m_str.size()) return m_str[k];
`endif
    return (k < 0) ? 32'hDEAD : 32'd0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_valid = 0; m_rd = '0;
    for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_sh[i] = 0; end
    m_tr.delete(); m_str.delete();
  endtask

  task automatic model_step();
    longint unsigned pre [4];
    logic [31:0] pre_tr [$];
    bit hit;
    pre = m_cnt;
    pre_tr = m_tr;
    if (rd_req) m_rd = shadow_word(rd_addr);
    m_valid = rd_req;
    hit = 0;
    if (clr) begin
      if (snap) begin m_sh = pre; m_str = pre_tr; end
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_tr.delete();
      m_run = 0; m_done = 0;
    end else begin
      if (m_run) begin
        m_cnt[0] = sat_inc(m_cnt[0]);
        if (stall && !flush) m_cnt[1] = sat_inc(m_cnt[1]);
        if (flush) begin
          m_cnt[2] = sat_inc(m_cnt[2]);
          m_tr.push_front(pc);
          if (m_tr.size() > TRACE_DEPTH) void'(m_tr.pop_back());
        end
        if (retire) m_cnt[3] = sat_inc(m_cnt[3]);
        hit = (MAX_CYCLES != 0) && (m_cnt[0] == MAX_CYCLES) && (pre[0] != m_cnt[0]);
      end
      if (hit) begin
        m_sh = m_cnt; m_str = m_tr; m_run = 0; m_done = 1;
      end else begin
        if (snap) begin m_sh = pre; m_str = pre_tr; end
        if (m_run && !start) m_run = 0;
        else if (!m_run && !m_done && start) m_run = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("running", 64'(running), 64'(m_run));
    check("done", 64'(done), 64'(m_done));
    check("rd_valid", 64'(rd_valid), 64'(m_valid));
    check("rd_data", 64'(rd_data), 64'(m_rd));
  endtask

  task automatic quiet();
    stall = 0; flush = 0; retire = 0; snap = 0; clr = 0; rd_req = 0;
  endtask

  task automatic read_const(input logic [2:0] a, input logic [31:0] exp, input string tag);
    rd_req = 1; rd_addr = a;
    step();
    rd_req = 0;
    check({tag, "_valid"}, 64'(rd_valid), 64'd1);
    check(tag, 64'(rd_data), 64'(exp));
  endtask

  task automatic pulse_clr();
    clr = 1; step(); clr = 0;
  endtask

  task automatic pulse_snap();
    snap = 1; step(); snap = 0;
  endtask

  initial begin
    rst_n = 0; start = 0; pc = '0; rd_addr = '0;
    quiet();
    start2 = 0; retire2 = 0; snap2 = 0; rd_req2 = 0; rd_addr2 = '0;
    model_reset();
    #12;
    check("rst_running", 64'(running), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_data", 64'(rd_data), 64'd0);
    @(negedge clk);
    rst_n = 1;

    // Ten cycles of start with a two-cycle stall window.
    start = 1;
    for (int i = 0; i < 10; i++) begin
      stall = (i == 3 || i == 4);
      step();
    end
    stall = 0; start = 0;
    step();
    pulse_snap();
    read_const(3'd0, 32'd10, "t1_cycle");
    read_const(3'd1, 32'd2, "t1_stall");
    read_const(3'd2, 32'd0, "t1_flush");
    read_const(3'd3, 32'd0, "t1_retire");
    step();
    check("t1_valid_pulse", 64'(rd_valid), 64'd0);

    // Stall coinciding with flush is a flush.
    pulse_clr();
    start = 1; step();
    stall = 1; flush = 1;
    for (int i = 0; i < 3; i++) step();
    stall = 0; flush = 0; start = 0;
    step();
    pulse_snap();
    read_const(3'd1, 32'd0, "t2_stall");
    read_const(3'd2, 32'd3, "t2_flush");

    // Uninterrupted run to MAX_CYCLES, then frozen.
    pulse_clr();
    start = 1; retire = 1;
    for (int i = 0; i < MAX_CYCLES + 1; i++) step();
    check("t3_done", 64'(done), 64'd1);
    read_const(3'd0, MAX_CYCLES, "t3_cycle_auto");
    flush = 1;
    for (int i = 0; i < 5; i++) step();
    flush = 0; retire = 0;
    pulse_snap();
    read_const(3'd3, MAX_CYCLES, "t3_retire_frozen");
    read_const(3'd2, 32'd0, "t3_flush_frozen");
    check("t3_done_held", 64'(done), 64'd1);

    // clr + snap with a flush in the same edge.
    pulse_clr();
    start = 1; step();
    flush = 1;
    for (int i = 0; i < 5; i++) step();
    clr = 1; snap = 1;
    step();
    clr = 0; snap = 0; flush = 0; start = 0;
    check("t4_idle", 64'(running), 64'd0);
    read_const(3'd2, 32'd5, "t4_shadow_flush");
    pulse_snap();
    read_const(3'd2, 32'd0, "t4_live_flush");

    // Narrow counter saturation on the second instance.
    start2 = 1; step();
    retire2 = 1;
    for (int i = 0; i < 20; i++) step();
    retire2 = 0; snap2 = 1; step(); snap2 = 0;
    rd_req2 = 1; rd_addr2 = 3'd3; step(); rd_req2 = 0;
    check("t5_valid", 64'(rd_valid2), 64'd1);
    check("t5_retire_sat", 64'(rd_data2), 64'd15);
    rd_req2 = 1; rd_addr2 = 3'd0; step(); rd_req2 = 0;
    check("t5_cycle_sat", 64'(rd_data2), 64'd15);
    check("t5_never_done", 64'(done2), 64'd0);
    start2 = 0;

    // Flush PC trace.
    pulse_clr();
    start = 1; step();
    for (int i = 1; i <= 5; i++) begin
      flush = 1; pc = 32'(i * 16);
      step();
    end
    flush = 0; start = 0;
    step();
    pulse_snap();
`ifdef PERF_FLUSH_TRACE_EN
    read_const(3'd4, 32'h50, "t6_trace0");
    read_const(3'd5, 32'h40, "t6_trace1");
    read_const(3'd6, 32'h30, "t6_trace2");
    read_const(3'd7, 32'h20, "t6_trace3");
`else
    read_const(3'd4, 32'd0, "t6_trace_absent");
`endif

    // Random traffic against the model.
    pulse_clr();
    for (int i = 0; i < 800; i++) begin
      start   = ($urandom_range(99) < 92);
      stall   = ($urandom_range(99) < 25);
      flush   = ($urandom_range(99) < 15);
      retire  = ($urandom_range(99) < 60);
      snap    = ($urandom_range(99) < 10);
      clr     = ($urandom_range(99) < 2);
      rd_req  = ($urandom_range(99) < 50);
      rd_addr = 3'($urandom_range(7));
      pc      = $urandom;
      step();
    end
    quiet();

    // Asynchronous reset mid-run.
    start = 1;
    for (int i = 0; i < 6; i++) step();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check("arst_running", 64'(running), 64'd0);
    check("arst_valid", 64'(rd_valid), 64'd0);
    check("arst_data", 64'(rd_data), 64'd0);
    start = 0;
    @(negedge clk);
    rst_n = 1;
    pulse_snap();
    read_const(3'd0, 32'd0, "arst_cycle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
